// File: rtl/seg7_pkg.sv
// seg7_pkg: shared font table, segment bit positions and prescaler sizing for the seg7 scan driver.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high patterns, bit order g..a
    localparam logic [6:0] FONT_0 = 7'h3F;
    localparam logic [6:0] FONT_1 = 7'h06;
    localparam logic [6:0] FONT_2 = 7'h5B;
    localparam logic [6:0] FONT_3 = 7'h4F;
    localparam logic [6:0] FONT_4 = 7'h66;
    localparam logic [6:0] FONT_5 = 7'h6D;
    localparam logic [6:0] FONT_6 = 7'h7D;
    localparam logic [6:0] FONT_7 = 7'h07;
    localparam logic [6:0] FONT_8 = 7'h7F;
    localparam logic [6:0] FONT_9 = 7'h6F;
    localparam logic [6:0] FONT_A = 7'h77;
    localparam logic [6:0] FONT_B = 7'h7C;
    localparam logic [6:0] FONT_C = 7'h39;
    localparam logic [6:0] FONT_D = 7'h5E;
    localparam logic [6:0] FONT_E = 7'h79;
    localparam logic [6:0] FONT_F = 7'h71;

    localparam logic [15:0][6:0] FONT = {
        FONT_F, FONT_E, FONT_D, FONT_C, FONT_B, FONT_A, FONT_9, FONT_8,
        FONT_7, FONT_6, FONT_5, FONT_4, FONT_3, FONT_2, FONT_1, FONT_0
    };

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// seg7_hex_font: combinational hex nibble to active-high a..g segment pattern.
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    always_comb begin
        pat = FONT[nib];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed DIGITS-digit seven-segment driver.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;

    logic                tick, last, boundary, blank, dp_sel;
    logic [3:0]          nib;
    logic [6:0]          pat;
    logic [7:0]          seg_raw;
    logic [DIGITS-1:0]   an_hot;

    seg7_hex_font u_font (
        .nib (nib),
        .pat (pat)
    );

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        an_hot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib       = disp_val_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                an_hot[i] = 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [IW-1:0] top_idx;

    // Highest nonzero nibble; digits above it are blanked
    always_comb begin
        top_idx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (disp_val_q[4*i +: 4] != 4'h0) top_idx = IW'(i);
        end
        blank = idx_q > top_idx;
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        seg_raw                = 8'h00;
        seg_raw[SEG_G:SEG_A]   = blank ? 7'h00 : pat;
        seg_raw[SEG_DP]        = dp_sel;
        tick                   = en && (cnt_q == CNT_LAST);
        last                   = idx_q == IDX_LAST;
        boundary               = tick && last;
        cnt_d                  = en ? (tick ? '0 : cnt_q + CW'(1)) : cnt_q;
        idx_d                  = tick ? (last ? '0 : idx_q + IW'(1)) : idx_q;
        seg_d                  = !en ? SEG_OFF : tick ? ((SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw) : seg_q;
        an_d                   = !en ? AN_OFF : tick ? ((AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot) : an_q;
        frame_done_d           = boundary;
        pend_val_d             = load ? value : pend_val_q;
        pend_dp_d              = load ? dp : pend_dp_q;
        // A load landing on the boundary goes straight to the display buffer
        disp_val_d             = boundary ? (load ? value : pend_val_q) : disp_val_q;
        disp_dp_d              = boundary ? (load ? dp : pend_dp_q) : disp_dp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the 4-digit, CLK_DIV=4, active-low scan driver.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(4),
        .CLK_DIV(4),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .load(load),
        .value(value),
        .dp(dp),
        .seg(seg),
        .an(an),
        .frame_done(frame_done)
    );

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] p);
        int top = 0;
        for (int i = 1; i < 4; i++) if (v[4*i +: 4] != 4'h0) top = i;
        for (int d = 0; d < 4; d++) begin
            logic [6:0] f;
            logic [3:0] a;
            f = font(v[4*d +: 4]);
`ifdef SEG7_LZ_BLANK_EN
            if (d > top) f = 7'h00;
`endif
            a = ~(4'b0001 << d);
            sb.push_back({a, ~{p[d], f}});
        end
    endtask

    task automatic check_off(input string name);
        checks++;
        if ({an, seg, frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL %s an/seg/fd=%h/%h/%b expected F/FF/0", name, an, seg, frame_done);
        end
    endtask

    // Entered on the first cycle of digit 0; returns on the first cycle of the next frame's digit 0
    task automatic check_frame(input int ld_slot, input logic [15:0] lv, input logic [3:0] ldp);
        for (int d = 0; d < 4; d++) begin
            logic [11:0] e;
            e = 12'h000;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty digit=%0d got nothing expected an entry", d);
            end else e = sb.pop_front();
            for (int c = 0; c < 4; c++) begin
                checks++;
                if ({an, seg} !== e) begin
                    failures++;
                    $display("FAIL scan d=%0d c=%0d an/seg=%h/%h expected %h/%h", d, c, an, seg, e[11:8], e[7:0]);
                end
                checks++;
                if (frame_done !== ((d == 3) && (c == 0))) begin
                    failures++;
                    $display("FAIL frame_done d=%0d c=%0d got %b expected %b", d, c, frame_done, (d == 3) && (c == 0));
                end
                if (4*d + c == ld_slot) begin
                    load = 1'b1;
                    value = lv;
                    dp = ldp;
                end else load = 1'b0;
                @(negedge clk);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_off("reset_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_off("post_reset_1");
        load = 1'b1;
        value = 16'h1234;
        dp = 4'h0;
        @(negedge clk);
        load = 1'b0;
        check_off("post_reset_2");
        @(negedge clk);
        check_off("post_reset_3");
        @(negedge clk);
    endtask

    task automatic test_first_frames();
        push_frame(16'h0000, 4'h0);
        check_frame(-1, 16'h0, 4'h0);
        push_frame(16'h1234, 4'h0);
        check_frame(5, 16'hABCD, 4'h0);
    endtask

    task automatic test_bypass();
        push_frame(16'hABCD, 4'h0);
        check_frame(11, 16'h00F0, 4'h0);
        push_frame(16'h00F0, 4'h0);
        check_frame(-1, 16'h0, 4'h0);
    endtask

    task automatic test_enable();
        checks++;
        if ({an, seg} !== {4'hE, ~{1'b0, font(4'h0)}}) begin
            failures++;
            $display("FAIL en_pre an/seg=%h/%h expected E/%h", an, seg, ~{1'b0, font(4'h0)});
        end
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_off("en_low");
        end
        en = 1'b1;
        @(negedge clk);
        check_off("resume_1");
        @(negedge clk);
        check_off("resume_2");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg} !== {4'hD, ~{1'b0, font(4'hF)}}) begin
                failures++;
                $display("FAIL resume_digit1 c=%0d an/seg=%h/%h expected D/%h", c, an, seg, ~{1'b0, font(4'hF)});
            end
        end
        repeat (9) @(negedge clk);
    endtask

    task automatic test_dp_blank();
        push_frame(16'h00F0, 4'h0);
        check_frame(0, 16'h0000, 4'b0010);
        push_frame(16'h0000, 4'b0010);
        check_frame(-1, 16'h0, 4'h0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_off("async_reset");
        @(posedge clk);
        #1 check_off("reset_after_edge");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_off("restart_idle");
        end
        @(negedge clk);
        push_frame(16'h0000, 4'h0);
        check_frame(-1, 16'h0, 4'h0);
        push_frame(16'h0000, 4'h0);
        check_frame(-1, 16'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_bypass();
        test_enable();
        test_dp_blank();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
